regfile_multiport: RTL and testbench

- Parametrised successor to the CPU's two-write/two-read register file.
- Holds NUM_REGS x DATA_WIDTH architectural registers, with configurable read and write port counts.
- Adds a write-through bypass and a per-register busy scoreboard for long-latency writers (loads, multiply, divide), so decode can stall on operands that are not ready.
- Sits between the decode/operand-fetch stage and the write-back muxes.

---
 rtl/regfile_multiport.sv | 87 ++++++++
 tb/tb_regfile_multiport.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multiport architectural register file with same-cycle write bypass and a
// per-register busy scoreboard that lets decode stall on long-latency results.
module regfile_multiport #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              writeSquash,
  input  logic [WRITE_PORTS-1:0]            writeEn,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] writeAddr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeData,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  readAddr,
  input  logic                              markEn,
  input  logic [ADDR_WIDTH-1:0]             markAddr,
  input  logic                              flushBusy,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  readData,
  output logic [READ_PORTS-1:0]             readReady,
  output logic                              anyBusy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    busy_next;
  logic [WRITE_PORTS-1:0] wr_eff;

  // A write only counts when no exception is pending and no reset is in progress.
  assign wr_eff = writeEn & {WRITE_PORTS{!writeSquash && !reset}};

  // Priority, lowest to highest: flush, write-clear, mark.
  // The squash blocks every busy-clear this cycle, the flush included.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and assign a default
    // first, so later statements override earlier ones and no latch is inferred.
    busy_next = busy;
    if (flushBusy && !writeSquash) busy_next = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wr_eff[p]) busy_next[writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (markEn) busy_next[markAddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is cleared on reset because software is
      // allowed to rely on all-zero architectural state; this rules out a
      // RAM macro, so keep it in flops.
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_next;
      // NOTE: sequential state uses non-blocking assignments; with several
      // ports hitting the same index, the last (highest-index) one wins.
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_eff[p])
          regs[writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= writeData[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    readData  = '0;
    readReady = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      readData[r*DATA_WIDTH +: DATA_WIDTH] = regs[readAddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      readReady[r] = !busy[readAddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0) begin
        // Ascending scan so the highest-index matching port is forwarded.
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (wr_eff[p] &&
              writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == readAddr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
            readData[r*DATA_WIDTH +: DATA_WIDTH] = writeData[p*DATA_WIDTH +: DATA_WIDTH];
            readReady[r] = 1'b1;
          end
        end
      end
    end
  end

  assign anyBusy = |busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: drives a BYPASS=1 and a BYPASS=0 instance in
// lockstep and compares both against an array-based model every cycle.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_squash;
  logic [1:0]  write_en;
  logic [9:0]  write_addr;
  logic [63:0] write_data;
  logic [9:0]  read_addr;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        flush_busy;

  logic [63:0] rd_data_b, rd_data_nb;
  logic [1:0]  rd_rdy_b, rd_rdy_nb;
  logic        any_busy_b, any_busy_nb;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(rst), .writeSquash(write_squash), .writeEn(write_en),
    .writeAddr(write_addr), .writeData(write_data), .readAddr(read_addr),
    .markEn(mark_en), .markAddr(mark_addr), .flushBusy(flush_busy),
    .readData(rd_data_b), .readReady(rd_rdy_b), .anyBusy(any_busy_b)
  );

  regfile_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(rst), .writeSquash(write_squash), .writeEn(write_en),
    .writeAddr(write_addr), .writeData(write_data), .readAddr(read_addr),
    .markEn(mark_en), .markAddr(mark_addr), .flushBusy(flush_busy),
    .readData(rd_data_nb), .readReady(rd_rdy_nb), .anyBusy(any_busy_nb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit effective(input int p);
    return write_en[p] && !write_squash && !rst;
  endfunction

  // Expected outputs straight from the rules: stored value and !busy, unless a
  // same-cycle effective write to the address is forwarded (bypass only).
  task automatic compare();
    for (int r = 0; r < 2; r++) begin
      logic [4:0]  a;
      logic [31:0] fwd;
      bit          hit;
      a   = read_addr[r*5 +: 5];
      hit = 1'b0;
      fwd = '0;
      for (int p = 0; p < 2; p++) begin
        if (effective(p) && write_addr[p*5 +: 5] == a) begin
          hit = 1'b1;
          fwd = write_data[p*32 +: 32];
        end
      end
      check($sformatf("byp rd%0d data r%0d", r, a), rd_data_b[r*32 +: 32], hit ? fwd : m_regs[a]);
      check($sformatf("byp rd%0d ready r%0d", r, a), {31'b0, rd_rdy_b[r]}, {31'b0, hit || !m_busy[a]});
      check($sformatf("nob rd%0d data r%0d", r, a), rd_data_nb[r*32 +: 32], m_regs[a]);
      check($sformatf("nob rd%0d ready r%0d", r, a), {31'b0, rd_rdy_nb[r]}, {31'b0, !m_busy[a]});
    end
    check("byp anyBusy", {31'b0, any_busy_b}, {31'b0, |m_busy});
    check("nob anyBusy", {31'b0, any_busy_nb}, {31'b0, |m_busy});
  endtask

  task automatic model_edge();
    logic [31:0] nb;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      if (flush_busy && !write_squash) nb = '0;
      for (int p = 0; p < 2; p++) begin
        if (effective(p)) begin
          m_regs[write_addr[p*5 +: 5]] = write_data[p*32 +: 32];
          nb[write_addr[p*5 +: 5]] = 1'b0;
        end
      end
      if (mark_en) nb[mark_addr] = 1'b1;
      m_busy = nb;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; write_squash = 1'b0; write_en = '0; write_addr = '0;
    write_data = '0; read_addr = '0; mark_en = 1'b0; mark_addr = '0; flush_busy = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    write_en[p] = 1'b1;
    write_addr[p*5 +: 5] = a;
    write_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int r, input logic [4:0] a);
    read_addr[r*5 +: 5] = a;
  endtask

  task automatic mark(input logic [4:0] a);
    mark_en = 1'b1;
    mark_addr = a;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    advance();

    // Every register reads zero and ready after reset.
    for (int a = 0; a < 32; a++) begin
      idle(); rd(0, 5'(a)); rd(1, 5'(31 - a));
      sample();
      check("reset r data", rd_data_b[31:0], 32'h0);
      check("reset ready", {30'b0, rd_rdy_b}, 32'h3);
      advance();
    end

    // Same-cycle bypass versus storage-only read.
    idle(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    sample();
    check("bypass r5 same cycle", rd_data_b[31:0], 32'hDEADBEEF);
    check("no-bypass r5 same cycle", rd_data_nb[31:0], 32'h0);
    advance();
    idle(); rd(0, 5);
    sample();
    check("no-bypass r5 next cycle", rd_data_nb[31:0], 32'hDEADBEEF);
    advance();

    // Write conflict: port 1 wins.
    idle(); wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); rd(1, 7);
    sample();
    check("conflict bypass r7", rd_data_b[63:32], 32'h22222222);
    advance();
    idle(); rd(0, 7);
    sample();
    check("conflict r7 stored", rd_data_nb[31:0], 32'h22222222);
    advance();

    // Mark r9, stall, then the late write clears it.
    idle(); mark(9); rd(0, 9);
    sample(); advance();
    idle(); rd(0, 9);
    sample();
    check("r9 busy ready", {31'b0, rd_rdy_b[0]}, 32'h0);
    check("r9 anyBusy", {31'b0, any_busy_b}, 32'h1);
    advance();
    idle(); wr(0, 9, 32'h0000ABCD); rd(0, 9);
    sample();
    check("r9 fwd ready", {31'b0, rd_rdy_b[0]}, 32'h1);
    check("r9 fwd data", rd_data_b[31:0], 32'h0000ABCD);
    check("r9 no-bypass stall", {31'b0, rd_rdy_nb[0]}, 32'h0);
    advance();
    idle(); rd(0, 9);
    sample();
    check("r9 busy cleared", {31'b0, any_busy_b}, 32'h0);
    advance();

    // Squashed write leaves data and busy alone; flush clears busy.
    idle(); mark(3);
    sample(); advance();
    idle(); write_squash = 1'b1; wr(0, 3, 32'h12345678); rd(0, 3);
    sample(); advance();
    idle(); rd(0, 3);
    sample();
    check("squash r3 data", rd_data_b[31:0], 32'h0);
    check("squash r3 still busy", {31'b0, rd_rdy_b[0]}, 32'h0);
    advance();
    idle(); flush_busy = 1'b1;
    sample(); advance();
    idle(); rd(0, 3);
    sample();
    check("flush anyBusy", {31'b0, any_busy_b}, 32'h0);
    advance();

    // Mark and write the same register: data stored, busy kept.
    idle(); mark(4); wr(0, 4, 32'h5);
    sample(); advance();
    idle(); rd(0, 4);
    sample();
    check("mark+write r4 data", rd_data_nb[31:0], 32'h5);
    check("mark+write r4 busy", {31'b0, rd_rdy_b[0]}, 32'h0);
    advance();

    // Reset with a pending mark and write discards both.
    idle(); rst = 1'b1; mark(6); wr(1, 6, 32'hFFFF0000); rd(1, 6);
    sample(); advance();
    idle(); rd(0, 4); rd(1, 6);
    sample();
    check("post-reset r4", rd_data_b[31:0], 32'h0);
    check("post-reset r6", rd_data_b[63:32], 32'h0);
    check("post-reset ready", {30'b0, rd_rdy_b}, 32'h3);
    check("post-reset anyBusy", {31'b0, any_busy_b}, 32'h0);
    advance();

    // Dual-port conflict sweep up to the top register index.
    for (int i = 0; i < 8; i++) begin
      idle();
      wr(0, 5'(i*4 + 3), 32'h5A000000 | i);
      wr(1, 5'(i*4 + 3), 32'hA5000000 | i);
      rd(0, 5'(i*4 + 3)); rd(1, 5'(i*4 + 31));
      sample(); advance();
    end
    idle(); rd(0, 31); rd(1, 0);
    sample();
    check("r31 sweep", rd_data_b[31:0], 32'hA5000007);
    advance();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
